booth_product_accumulator: RTL and testbench
============================================

// Module: booth_product_accumulator
// PURPOSE
//   Downstream stage of the combinational radix-4 Booth multiplier.
//   Takes its signed 2*WIDTH product over a valid/ready handshake and sign-extends it.
//   Accumulates COUNT products into an ACC_WIDTH signed sum, then presents the sum
//   over a valid/ready output handshake.
//   Forms the accumulate half of a dot-product / MAC path.
// PARAMETERS
//   WIDTH      8   multiplier operand width; product width is 2*WIDTH
//   ACC_WIDTH  24  accumulator width; must be >= 2*WIDTH (elaboration error otherwise)
//   COUNT      4   products per result, >= 1; counter width = $clog2(COUNT)+1
// PORTS
//   clk         in   1          rising-edge clock
//   rst         in   1          synchronous reset, active-high
//   prod_valid  in   1          product is valid this cycle
//   prod_ready  out  1          stage accepts a product this cycle
//   product     in   2*WIDTH    signed two's-complement product from Booth multiplier
//   acc_clr     in   1          discard partial sum, restart frame (ACC state only)
//   acc_valid   out  1          acc_out holds a completed sum
//   acc_ready   in   1          consumer takes acc_out this cycle
//   acc_out     out  ACC_WIDTH  signed accumulated sum
//   acc_ovf     out  1          sticky: signed overflow occurred within this frame
// BEHAVIOUR
//   - Reset (rst=1 at clk edge):
//       state=ACC, acc=0, cnt=0, acc_valid=0, acc_out=0, acc_ovf=0.
//       prod_ready=0 while rst is high.
//   - States:
//       ACC  (collecting): prod_ready=1, acc_valid=0.
//       DONE (holding):    prod_ready=0, acc_valid=1.
//   - Accept: prod_valid & prod_ready.
//       acc <= acc + sext(product); cnt <= cnt+1.
//   - Accept with cnt==COUNT-1: go to DONE.
//       acc_valid=1 on the cycle after the last accept (latency 1).
//   - DONE: acc_out and acc_ovf are stable. prod_valid, product and acc_clr are ignored.
//   - DONE with acc_valid & acc_ready: acc=0, cnt=0, acc_ovf=0, state=ACC.
//       Next cycle: acc_valid=0, prod_ready=1.
//   - acc_clr in ACC without accept: acc=0, cnt=0, acc_ovf=0.
//   - acc_clr together with accept:
//       acc=sext(product), cnt=1, acc_ovf=0.
//       If COUNT==1, go straight to DONE.
//   - Arithmetic is modulo 2^ACC_WIDTH (wraps, no saturation).
//   - Overflow: addend and acc have the same sign and the sum sign differs.
//       acc_ovf is set and held until the result handshake, acc_clr, or rst.
//   - acc_out is the registered acc. It is only meaningful while acc_valid=1.
//   - Reset mid-frame or in DONE discards all state. Any pending result is lost.
//   - No combinational path from acc_ready to prod_ready. prod_ready decodes state only.
// TESTING (WIDTH=8, COUNT=4; products from multiplicand 0x55)
//   1. Hold rst 3 cycles, release.
//      -> acc_valid=0, acc_out=0, acc_ovf=0; prod_ready=1 on the first cycle after release.
//   2. ACC_WIDTH=24. Products 0x00FF, 0x00FF, 0xFF56, 0x0001 on consecutive cycles.
//      -> acc_valid=1 one cycle after the 4th, acc_out=0x000155, acc_ovf=0.
//   3. Same frame with acc_ready=0 for 5 cycles, prod_valid=1 with 0x0003 throughout.
//      -> acc_out stays 0x000155, prod_ready=0, nothing accumulated.
//      -> After the handshake: acc_valid=0, prod_ready=1, next frame starts from 0.
//   4. ACC_WIDTH=16. Four products 0x2A2B (85*127).
//      -> acc_out=0xA8AC (wrapped), acc_ovf=1. acc_ovf=0 after the handshake.
//   5. Accept 0x0010, 0x0010; then acc_clr=1 with product 0x0005; then 0x0001 x3.
//      -> acc_out=0x000008, acc_valid after the 3rd 0x0001.
//   6. Pulse rst during DONE (acc_out=0x000155).
//      -> Next cycle acc_valid=0, acc_out=0, prod_ready=1 after release, cnt restarts at 0.

Source files
------------

// File: rtl/booth_product_accumulator_if.sv
// rtl/booth_product_accumulator_if.sv - product-in / sum-out handshake bundle for the Booth product accumulator
//   prod_valid/prod_ready/product : product stream from the Booth multiplier
//   acc_clr                       : restart the current frame
//   acc_valid/acc_ready/acc_out   : completed-sum stream to the consumer
//   acc_ovf                       : sticky signed overflow flag for the presented frame
//   master = upstream producer plus downstream consumer; slave = the accumulator
interface booth_product_accumulator_if #(
    parameter int WIDTH     = 8,
    parameter int ACC_WIDTH = 24
);
    logic                   prod_valid;
    logic                   prod_ready;
    logic [2*WIDTH-1:0]     product;
    logic                   acc_clr;
    logic                   acc_valid;
    logic                   acc_ready;
    logic [ACC_WIDTH-1:0]   acc_out;
    logic                   acc_ovf;

    modport master (
        output prod_valid, product, acc_clr, acc_ready,
        input  prod_ready, acc_valid, acc_out, acc_ovf
    );

    modport slave (
        input  prod_valid, product, acc_clr, acc_ready,
        output prod_ready, acc_valid, acc_out, acc_ovf
    );
endinterface

// File: rtl/booth_product_accumulator.sv
// rtl/booth_product_accumulator.sv - accumulates COUNT signed Booth products into one signed sum
//   clk  : rising-edge clock
//   rst  : synchronous reset, active-high
//   bus  : slave side of booth_product_accumulator_if (product in, sum out, clear, overflow)
module booth_product_accumulator #(
    parameter int WIDTH     = 8,
    parameter int ACC_WIDTH = 24,
    parameter int COUNT     = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    booth_product_accumulator_if.slave    bus
);
    localparam int CW = $clog2(COUNT) + 1;

    if (ACC_WIDTH < 2*WIDTH) begin : g_bad_acc_width
        $error("ACC_WIDTH must be at least 2*WIDTH");
    end
    if (COUNT < 1) begin : g_bad_count
        $error("COUNT must be at least 1");
    end

    typedef enum logic {ST_ACC, ST_DONE} state_t;

    state_t                         state_q, state_d;
    logic signed [ACC_WIDTH-1:0]    acc_q, acc_d;
    logic        [CW-1:0]           cnt_q, cnt_d;
    logic                           ovf_q, ovf_d;

    logic signed [2*WIDTH-1:0]      prod_s;
    logic signed [ACC_WIDTH-1:0]    addend;
    logic signed [ACC_WIDTH-1:0]    base_acc;
    logic signed [ACC_WIDTH-1:0]    sum;
    logic        [CW-1:0]           base_cnt;
    logic                           base_ovf;
    logic                           accept;
    logic                           step_ovf;

    assign prod_s = $signed(bus.product);
    assign addend = ACC_WIDTH'(prod_s);
    assign accept = bus.prod_valid && (state_q == ST_ACC);

    // A clear that coincides with an accept starts the new frame with this
    // product, so the add runs against a zeroed base instead of the old sum.
    assign base_acc = bus.acc_clr ? '0 : acc_q;
    assign base_cnt = bus.acc_clr ? '0 : cnt_q;
    assign base_ovf = bus.acc_clr ? 1'b0 : ovf_q;
    assign sum      = base_acc + addend;
    assign step_ovf = (base_acc[ACC_WIDTH-1] == addend[ACC_WIDTH-1]) &&
                      (sum[ACC_WIDTH-1] != base_acc[ACC_WIDTH-1]);

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        case (state_q)
            ST_ACC: begin
                if (accept) begin
                    acc_d = sum;
                    cnt_d = base_cnt + CW'(1);
                    ovf_d = base_ovf | step_ovf;
                    if (base_cnt == CW'(COUNT-1)) begin
                        state_d = ST_DONE;
                    end
                end else if (bus.acc_clr) begin
                    acc_d = '0;
                    cnt_d = '0;
                    ovf_d = 1'b0;
                end
            end
            ST_DONE: begin
                if (bus.acc_ready) begin
                    state_d = ST_ACC;
                    acc_d   = '0;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                end
            end
            default: state_d = ST_ACC;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_ACC;
            acc_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

    // prod_ready depends only on state (and reset), never on acc_ready.
    assign bus.prod_ready = !rst && (state_q == ST_ACC);
    assign bus.acc_valid  = (state_q == ST_DONE);
    assign bus.acc_out    = acc_q;
    assign bus.acc_ovf    = ovf_q;
endmodule

// File: tb/tb_booth_product_accumulator.sv
// tb/tb_booth_product_accumulator.sv - randomized self-checking bench for booth_product_accumulator
module tb_booth_product_accumulator;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        prod_valid;
    logic [15:0] product;
    logic        acc_clr;
    logic        acc_ready;

    booth_product_accumulator_if #(.WIDTH(8), .ACC_WIDTH(24)) bus24 ();
    booth_product_accumulator_if #(.WIDTH(8), .ACC_WIDTH(16)) bus16 ();

    assign bus24.prod_valid = prod_valid;
    assign bus24.product    = product;
    assign bus24.acc_clr    = acc_clr;
    assign bus24.acc_ready  = acc_ready;
    assign bus16.prod_valid = prod_valid;
    assign bus16.product    = product;
    assign bus16.acc_clr    = acc_clr;
    assign bus16.acc_ready  = acc_ready;

    booth_product_accumulator #(.WIDTH(8), .ACC_WIDTH(24), .COUNT(4)) dut24 (
        .clk (clk),
        .rst (rst),
        .bus (bus24)
    );

    booth_product_accumulator #(.WIDTH(8), .ACC_WIDTH(16), .COUNT(4)) dut16 (
        .clk (clk),
        .rst (rst),
        .bus (bus16)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Reference: a frame is a list of signed integers summed with wrap at
    // the accumulator width; overflow is any partial sum leaving signed range.
    bit     m_done;
    int     m_cnt;
    longint m_acc24, m_acc16;
    bit     m_ovf24, m_ovf16;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=0x%08h expected=0x%08h at %0t", tag, got, exp, $time);
    endtask

    function automatic void add_wrap(input int n, inout longint acc, inout bit ovf, input longint p);
        longint t, hi, lo, span;
        span = longint'(1) << n;
        hi   = (longint'(1) << (n-1)) - 1;
        lo   = -(longint'(1) << (n-1));
        t    = acc + p;
        if (t > hi || t < lo) ovf = 1'b1;
        t = t & (span - 1);
        if (t > hi) t = t - span;
        acc = t;
    endfunction

    function automatic logic [31:0] masked(input int n, input longint v);
        return 32'(v & ((longint'(1) << n) - 1));
    endfunction

    task automatic model_clear();
        m_cnt   = 0;
        m_acc24 = 0;
        m_acc16 = 0;
        m_ovf24 = 1'b0;
        m_ovf16 = 1'b0;
    endtask

    task automatic cycle(input logic pv, input logic [15:0] p, input logic clr,
                         input logic ar, input logic r);
        longint ps;
        prod_valid = pv;
        product    = p;
        acc_clr    = clr;
        acc_ready  = ar;
        rst        = r;
        #1;
        check("prod_ready24", 32'(bus24.prod_ready), 32'(!r && !m_done));
        check("prod_ready16", 32'(bus16.prod_ready), 32'(!r && !m_done));
        ps = longint'($signed(p));
        if (r) begin
            m_done = 1'b0;
            model_clear();
        end else if (!m_done) begin
            if (pv) begin
                if (clr) model_clear();
                add_wrap(24, m_acc24, m_ovf24, ps);
                add_wrap(16, m_acc16, m_ovf16, ps);
                m_cnt++;
                if (m_cnt == 4) m_done = 1'b1;
            end else if (clr) begin
                model_clear();
            end
        end else if (ar) begin
            m_done = 1'b0;
            model_clear();
        end
        @(posedge clk);
        #1;
        check("acc_valid24", 32'(bus24.acc_valid), 32'(m_done));
        check("acc_valid16", 32'(bus16.acc_valid), 32'(m_done));
        check("acc_out24",   32'(bus24.acc_out),   masked(24, m_acc24));
        check("acc_out16",   32'(bus16.acc_out),   masked(16, m_acc16));
        check("acc_ovf24",   32'(bus24.acc_ovf),   32'(m_ovf24));
        check("acc_ovf16",   32'(bus16.acc_ovf),   32'(m_ovf16));
    endtask

    task automatic frame_155();
        cycle(1'b1, 16'h00FF, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 16'h00FF, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 16'hFF56, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 16'h0001, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        logic signed [7:0]  a, b;
        logic signed [15:0] pr;
        m_done = 1'b0;
        model_clear();

        // 1: reset for three cycles
        repeat (3) cycle(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
        check("t1_valid", 32'(bus24.acc_valid), 32'h0);
        check("t1_out",   32'(bus24.acc_out),   32'h0);
        check("t1_ovf",   32'(bus24.acc_ovf),   32'h0);

        // 2: four products, sum 0x155
        frame_155();
        check("t2_valid", 32'(bus24.acc_valid), 32'h1);
        check("t2_out",   32'(bus24.acc_out),   32'h000155);
        check("t2_ovf",   32'(bus24.acc_ovf),   32'h0);

        // 3: back-pressure; products offered in DONE are ignored
        repeat (5) cycle(1'b1, 16'h0003, 1'b0, 1'b0, 1'b0);
        check("t3_hold",  32'(bus24.acc_out),   32'h000155);
        cycle(1'b1, 16'h0003, 1'b0, 1'b1, 1'b0);
        check("t3_after", 32'(bus24.acc_valid), 32'h0);
        check("t3_zero",  32'(bus24.acc_out),   32'h0);

        // 4: 16-bit accumulator wraps and flags overflow
        repeat (4) cycle(1'b1, 16'h2A2B, 1'b0, 1'b0, 1'b0);
        check("t4_out16", 32'(bus16.acc_out), 32'h0000A8AC);
        check("t4_ovf16", 32'(bus16.acc_ovf), 32'h1);
        check("t4_ovf24", 32'(bus24.acc_ovf), 32'h0);
        cycle(1'b0, 16'h0000, 1'b0, 1'b1, 1'b0);
        check("t4_ovf_clr", 32'(bus16.acc_ovf), 32'h0);

        // 5: clear coincident with an accept restarts the frame
        cycle(1'b1, 16'h0010, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 16'h0010, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 16'h0005, 1'b1, 1'b0, 1'b0);
        cycle(1'b1, 16'h0001, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 16'h0001, 1'b0, 1'b0, 1'b0);
        check("t5_early", 32'(bus24.acc_valid), 32'h0);
        cycle(1'b1, 16'h0001, 1'b0, 1'b0, 1'b0);
        check("t5_valid", 32'(bus24.acc_valid), 32'h1);
        check("t5_out",   32'(bus24.acc_out),   32'h000008);
        cycle(1'b0, 16'h0000, 1'b0, 1'b1, 1'b0);

        // clear without accept
        cycle(1'b1, 16'h0040, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
        check("clr_out", 32'(bus24.acc_out), 32'h0);
        frame_155();
        check("clr_frame", 32'(bus24.acc_out), 32'h000155);

        // 6: reset while holding a result
        cycle(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
        check("t6_valid", 32'(bus24.acc_valid), 32'h0);
        check("t6_out",   32'(bus24.acc_out),   32'h0);
        frame_155();
        check("t6_again", 32'(bus24.acc_out), 32'h000155);
        cycle(1'b0, 16'h0000, 1'b0, 1'b1, 1'b0);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            a  = ($urandom_range(0, 1) == 0) ? 8'sh55 : 8'($urandom);
            b  = 8'($urandom);
            pr = a * b;
            cycle($urandom_range(0, 9) < 7, pr,
                  $urandom_range(0, 9) == 0,
                  $urandom_range(0, 1) == 1,
                  $urandom_range(0, 49) == 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
